// File: rtl/i2s_out_serializer.sv
// Stereo I2S (Philips) output stage: buffers mixer sample pairs in a small FIFO and
// serializes one pair per frame. Define I2S_UNDERRUN_HOLD_EN to repeat the last pair on underrun.
module i2s_out_serializer #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                             sCLK_XVXENVS,
    input  logic                             reset_data,
    input  logic                             sample_valid,
    input  logic [AUD_BIT_DEPTH-1:0]         lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0]         rsound_in,
    input  logic                             i2s_en,
    input  logic                             clr_flags,
    output logic                             bclk,
    output logic                             lrck,
    output logic                             sdata,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             overflow,
    output logic                             underrun
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BC_W   = $clog2(2 * SLOT_BITS);
    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PAIR_W = 2 * AUD_BIT_DEPTH;

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SLOT_BITS - 1);
    localparam logic [BC_W-1:0]  BC_SLOT  = BC_W'(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [PAIR_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic [AUD_BIT_DEPTH-1:0] lhold_q, lhold_d, rhold_q, rhold_d;
    logic [BC_W-1:0]          bitcnt_q, bitcnt_d, bitcnt_nx;
    logic [DIV_W-1:0]         div_q, div_d;
    logic                     bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
    logic                     ovf_q, ovf_d, udr_q, udr_d;
    logic                     frame_start, pop, push, fifo_empty, tick, fall, wrap;

    // Slot position 0 carries the one-bit I2S delay; the sample follows MSB first, then zero padding.
    function automatic logic slot_bit(input logic [BC_W-1:0] bc,
                                      input logic [AUD_BIT_DEPTH-1:0] l,
                                      input logic [AUD_BIT_DEPTH-1:0] r);
        logic [AUD_BIT_DEPTH-1:0] smp;
        int p;
        logic b;
        b   = 1'b0;
        smp = (bc >= BC_SLOT) ? r : l;
        p   = (bc >= BC_SLOT) ? (int'(bc) - SLOT_BITS) : int'(bc);
        for (int i = 0; i < AUD_BIT_DEPTH; i++) begin
            if (p >= 1 && i == AUD_BIT_DEPTH - p) b = smp[i];
        end
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        div_d       = div_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        frame_start = 1'b0;
        tick        = (state_q != ST_IDLE) && (div_q == DIV_LAST);
        fall        = tick && bclk_q;
        wrap        = fall && (bitcnt_q == BC_LAST);
        bitcnt_nx   = wrap ? '0 : bitcnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                bclk_d   = 1'b0;
                lrck_d   = 1'b0;
                sdata_d  = 1'b0;
                div_d    = '0;
                bitcnt_d = '0;
                if (i2s_en) begin
                    state_d     = ST_RUN;
                    frame_start = 1'b1;
                end
            end
            default: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) bclk_d = ~bclk_q;
                if (fall) begin
                    bitcnt_d = bitcnt_nx;
                    lrck_d   = (bitcnt_nx >= BC_SLOT);
                    sdata_d  = slot_bit(bitcnt_nx, lhold_q, rhold_q);
                end
                if (state_q == ST_RUN) begin
                    if (wrap) frame_start = 1'b1;
                    if (!i2s_en) state_d = ST_DRAIN;
                end else if (i2s_en) begin
                    // Re-enabled while draining: keep the running frame, no restart.
                    state_d = ST_RUN;
                    if (wrap) frame_start = 1'b1;
                end else if (wrap) begin
                    state_d  = ST_IDLE;
                    bclk_d   = 1'b0;
                    lrck_d   = 1'b0;
                    sdata_d  = 1'b0;
                    div_d    = '0;
                    bitcnt_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        fifo_empty = (level_q == '0);
        pop        = frame_start && !fifo_empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push       = sample_valid && ((level_q != LVL_FULL) || pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

        lhold_d = lhold_q;
        rhold_d = rhold_q;
        if (pop) begin
            {lhold_d, rhold_d} = mem_q[rd_ptr_q];
        end else if (frame_start) begin
`ifdef I2S_UNDERRUN_HOLD_EN
            lhold_d = lhold_q;
            rhold_d = rhold_q;
`else
            lhold_d = '0;
            rhold_d = '0;
`endif
        end

        ovf_d = (ovf_q && !clr_flags) || (sample_valid && !push);
        udr_d = (udr_q && !clr_flags) || (frame_start && fifo_empty);
    end

    always_ff @(posedge sCLK_XVXENVS) begin
        if (push) mem_q[wr_ptr_q] <= {lsound_in, rsound_in};
    end

    always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
        if (reset_data) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lhold_q  <= '0;
            rhold_q  <= '0;
            bitcnt_q <= '0;
            div_q    <= '0;
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            lhold_q  <= lhold_d;
            rhold_q  <= rhold_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            lrck_q   <= lrck_d;
            sdata_q  <= sdata_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
        end
    end

    assign bclk       = bclk_q;
    assign lrck       = lrck_q;
    assign sdata      = sdata_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign underrun   = udr_q;

endmodule

// File: tb/tb_i2s_out_serializer.sv
// Bench for i2s_out_serializer: cycle-driven stimulus with a queue-level reference model
// and an I2S receiver monitor that reassembles whole frames and checks them against a scoreboard.
module tb_i2s_out_serializer;

    localparam int AW        = 24;
    localparam int SLOT      = 32;
    localparam int DIV       = 4;
    localparam int DEPTH     = 4;
    localparam int FW        = 2 * SLOT;
    localparam int FRAME_CLK = 4 * SLOT * DIV;
    localparam int PAD       = SLOT - 1 - AW;

    logic          clk = 1'b0;
    logic          reset_data, sample_valid, i2s_en, clr_flags;
    logic [AW-1:0] lsound_in, rsound_in;
    logic          bclk, lrck, sdata, overflow, underrun;
    logic [$clog2(DEPTH):0] fifo_level;

    always #5 clk = ~clk;

    i2s_out_serializer #(
        .AUD_BIT_DEPTH(AW), .SLOT_BITS(SLOT), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sCLK_XVXENVS(clk), .reset_data(reset_data), .sample_valid(sample_valid),
        .lsound_in(lsound_in), .rsound_in(rsound_in), .i2s_en(i2s_en), .clr_flags(clr_flags),
        .bclk(bclk), .lrck(lrck), .sdata(sdata), .fifo_level(fifo_level),
        .overflow(overflow), .underrun(underrun)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Reference model state
    logic [2*AW-1:0] mq[$];
    logic [2*AW-1:0] m_last;
    logic [FW-1:0]   exp_q[$];
    bit              m_active, m_ovf, m_udr;
    int              m_pos;
    bit              en_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [2*AW-1:0] pr);
        return {1'b0, pr[2*AW-1:AW], {PAD{1'b0}}, 1'b0, pr[AW-1:0], {PAD{1'b0}}};
    endfunction

    task automatic m_frame_start();
        logic [2*AW-1:0] pr;
        if (mq.size() > 0) begin
            pr = mq.pop_front();
            m_last = pr;
        end else begin
            m_udr = 1'b1;
`ifdef I2S_UNDERRUN_HOLD_EN
            pr = m_last;
`else
            pr = '0;
`endif
        end
        exp_q.push_back(frame_of(pr));
    endtask

    task automatic model_edge(input bit sv, input logic [AW-1:0] l, input logic [AW-1:0] r,
                              input bit clr, input bit en);
        bit start;
        start = 1'b0;
        if (clr) begin
            m_ovf = 1'b0;
            m_udr = 1'b0;
        end
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_pos    = 0;
                start    = 1'b1;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME_CLK) begin
                m_pos = 0;
                if (en) start = 1'b1;
                else m_active = 1'b0;
            end
        end
        if (start) m_frame_start();
        if (sv) begin
            if (mq.size() < DEPTH) mq.push_back({l, r});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input bit sv, input logic [AW-1:0] l, input logic [AW-1:0] r, input bit clr);
        @(negedge clk);
        sample_valid = sv;
        lsound_in    = l;
        rsound_in    = r;
        clr_flags    = clr;
        i2s_en       = en_req;
        @(posedge clk);
        if (!reset_data) model_edge(sv, l, r, clr, en_req);
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic step_to_pos(input int p);
        int guard;
        guard = 0;
        while (!(m_active && m_pos == p) && guard < 4 * FRAME_CLK) begin
            step(1'b0, '0, '0, 1'b0);
            guard++;
        end
        if (guard >= 4 * FRAME_CLK) begin
            chk_cnt++;
            $display("FAIL step_to_pos: position %0d not reached within %0d cycles", p, guard);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_active && guard < 2 * FRAME_CLK) begin
            step(1'b0, '0, '0, 1'b0);
            guard++;
        end
        if (guard >= 2 * FRAME_CLK) begin
            chk_cnt++;
            $display("FAIL wait_idle: frame did not end within %0d cycles", guard);
        end
        idle_steps(8);
    endtask

    task automatic chk_state(input string name);
        #1;
        chk({name, " level"}, fifo_level, mq.size());
        chk({name, " overflow"}, overflow, m_ovf);
        chk({name, " underrun"}, underrun, m_udr);
    endtask

    task automatic run_frames(input int n, input int drop_pos);
        en_req = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        repeat (FRAME_CLK * (n - 1)) step(1'b0, '0, '0, 1'b0);
        step_to_pos(drop_pos);
        en_req = 1'b0;
        wait_idle();
    endtask

    // Monitor: an I2S receiver sampling sdata on bclk rising edges
    int            cyc = 0;
    int            mon_cnt = 0;
    int            last_rise = 0;
    int            lr_rise_t = 0;
    bit            lr_rise_ok = 1'b0;
    logic          bclk_prev = 1'b0;
    logic          lrck_prev = 1'b0;
    logic [FW-1:0] mon_frame = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset_data) begin
            mon_cnt    = 0;
            lr_rise_ok = 1'b0;
        end else begin
            if (bclk && !bclk_prev) begin
                if (mon_cnt > 0) chk("bclk period", cyc - last_rise, 2 * DIV);
                last_rise = cyc;
                chk("lrck slot", lrck, mon_cnt >= SLOT);
                mon_frame = {mon_frame[FW-2:0], sdata};
                mon_cnt++;
                if (mon_cnt == FW) begin
                    mon_cnt = 0;
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL frame: got unexpected frame %h, expected none", mon_frame);
                    end else begin
                        chk("frame data", mon_frame, exp_q.pop_front());
                    end
                end
            end
            if (lrck && !lrck_prev) begin
                lr_rise_t  = cyc;
                lr_rise_ok = 1'b1;
            end
            if (!lrck && lrck_prev && lr_rise_ok) begin
                chk("lrck half-frame", cyc - lr_rise_t, SLOT * 2 * DIV);
                lr_rise_ok = 1'b0;
            end
        end
        bclk_prev = bclk;
        lrck_prev = lrck;
    end

    initial begin
        logic [AW-1:0] l, r;
        reset_data = 1'b1;
        sample_valid = 1'b0;
        lsound_in = '0;
        rsound_in = '0;
        i2s_en = 1'b0;
        clr_flags = 1'b0;
        en_req = 1'b0;
        m_last = '0;
        m_active = 1'b0;
        m_ovf = 1'b0;
        m_udr = 1'b0;
        m_pos = 0;

        idle_steps(3);
        #1;
        chk("reset outputs", {bclk, lrck, sdata, overflow, underrun}, 5'b0);
        chk("reset level", fifo_level, 0);
        @(negedge clk);
        reset_data = 1'b0;
        idle_steps(10);
        chk_state("post reset");
        chk("post reset bclk idle", {bclk, lrck, sdata}, 3'b0);

        // Basic frame
        step(1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0);
        chk_state("basic push");
        run_frames(1, 300);
        chk_state("basic done");

        // Overflow: five pushes while idle
        for (int i = 0; i < 5; i++) begin
            l = AW'($urandom);
            r = AW'($urandom);
            step(1'b1, l, r, 1'b0);
        end
        chk_state("overflow fill");
        chk("overflow level full", fifo_level, DEPTH);
        chk("overflow flag set", overflow, 1'b1);
        step(1'b1, 24'h111111, 24'h222222, 1'b1);
        chk_state("overflow set beats clear");
        step(1'b0, '0, '0, 1'b1);
        chk_state("overflow cleared");
        run_frames(4, 200);
        chk_state("overflow drained");

        // Underrun
        step(1'b1, 24'h123456, 24'h123456, 1'b1);
        en_req = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        chk_state("underrun first frame");
        repeat (FRAME_CLK) step(1'b0, '0, '0, 1'b0);
        chk_state("underrun second frame");
        chk("underrun flag set", underrun, 1'b1);
        step_to_pos(100);
        en_req = 1'b0;
        wait_idle();

        // Disable mid-frame at bitcnt 10
        step(1'b1, AW'($urandom), AW'($urandom), 1'b1);
        step(1'b1, AW'($urandom), AW'($urandom), 1'b0);
        en_req = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        step_to_pos(10 * 2 * DIV + DIV);
        en_req = 1'b0;
        wait_idle();
        idle_steps(20);
        chk_state("disable no pop");
        chk("disable outputs held", {bclk, lrck, sdata}, 3'b0);
        run_frames(1, 100);

        // Push/pop collision with a full FIFO
        step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'($urandom), AW'($urandom), 1'b0);
        en_req = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        step_to_pos(100);
        step(1'b1, AW'($urandom), AW'($urandom), 1'b0);
        step_to_pos(FRAME_CLK - 1);
        step(1'b1, AW'($urandom), AW'($urandom), 1'b0);
        chk_state("collision");
        chk("collision level full", fifo_level, DEPTH);
        chk("collision no overflow", overflow, 1'b0);
        repeat (FRAME_CLK * 4) step(1'b0, '0, '0, 1'b0);
        step_to_pos(100);
        en_req = 1'b0;
        wait_idle();
        chk_state("collision drained");

        // Random traffic, including a brief disable/re-enable inside one frame
        step(1'b0, '0, '0, 1'b1);
        en_req = 1'b1;
        for (int i = 0; i < 6 * FRAME_CLK; i++) begin
            if (i == 2 * FRAME_CLK + 100) en_req = 1'b0;
            if (i == 2 * FRAME_CLK + 160) en_req = 1'b1;
            step($urandom_range(0, 399) == 0, AW'($urandom), AW'($urandom), 1'b0);
            if (i % FRAME_CLK == 50) chk_state("random run");
        end
        step_to_pos(200);
        en_req = 1'b0;
        wait_idle();
        chk_state("random done");

        // Reset mid-frame
        step(1'b1, AW'($urandom), AW'($urandom), 1'b0);
        step(1'b1, AW'($urandom), AW'($urandom), 1'b0);
        en_req = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        step_to_pos(300);
        @(negedge clk);
        reset_data = 1'b1;
        en_req = 1'b0;
        i2s_en = 1'b0;
        #1;
        chk("midframe reset outputs", {bclk, lrck, sdata, overflow, underrun}, 5'b0);
        chk("midframe reset level", fifo_level, 0);
        mq.delete();
        exp_q.delete();
        m_last = '0;
        m_active = 1'b0;
        m_ovf = 1'b0;
        m_udr = 1'b0;
        idle_steps(3);
        @(negedge clk);
        reset_data = 1'b0;
        idle_steps(20);
        chk_state("after midframe reset");
        chk("after reset idle outputs", {bclk, lrck, sdata}, 3'b0);

        chk("scoreboard empty", exp_q.size(), 0);
        chk("monitor frame boundary", mon_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
